// File: rtl/reg_deskew_8l_pkg.sv
// Shared defaults and alignment classification for the output-side lane deskew block.
package reg_deskew_8l_pkg;

    localparam int DESKEW_DATA_WIDTH = 18;
    localparam int DESKEW_LANES      = 8;
    localparam int DESKEW_FIFO_DEPTH = 4;
    localparam int DESKEW_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ALIGN_IDLE = 2'd0,
        ALIGN_WORD = 2'd1,
        ALIGN_SKEW = 2'd2
    } align_e;

    // all_v / any_v are the AND / OR reductions of the realigned valid vector.
    function automatic align_e align_class(input logic all_v, input logic any_v);
        if (all_v) begin
            return ALIGN_WORD;
        end else if (any_v) begin
            return ALIGN_SKEW;
        end
        return ALIGN_IDLE;
    endfunction

endpackage

// File: rtl/reg_deskew_8l_fifo.sv
// Small synchronous FIFO with a registered head word; accepts a write into a full
// FIFO when the head is being read in the same cycle.
module deskew_fifo
    import reg_deskew_8l_pkg::*;
#(
    parameter int WIDTH = DESKEW_DATA_WIDTH * DESKEW_LANES,
    parameter int DEPTH = DESKEW_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             wr_drop
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE       = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      rd_ptr_nxt;
    logic [AW:0]      count_rem;
    logic             do_rd;
    logic             do_wr;

    always_comb begin
        do_rd      = rd_en && rd_valid;
        full       = (count == DEPTH_CNT);
        do_wr      = wr_en && (!full || do_rd);
        wr_drop    = wr_en && full && !do_rd;
        rd_ptr_nxt = do_rd ? rd_ptr + ONE : rd_ptr;
        count_rem  = do_rd ? count - ONE : count;
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Head is reloaded from the entry behind the one leaving, or straight from the
    // write port when that write is the only word left; an empty FIFO holds the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + ONE;
            end
            rd_ptr   <= rd_ptr_nxt;
            count    <= do_wr ? count_rem + ONE : count_rem;
            rd_valid <= do_wr || (count_rem != '0);
            if (count_rem == '0) begin
                if (do_wr) begin
                    rd_data <= wr_data;
                end
            end else begin
                rd_data <= mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/reg_deskew_8l.sv
// Realigns staircase-skewed result lanes from the systolic array into one wide word
// and buffers the words for a valid/ready consumer.
module reg_deskew_8l
    import reg_deskew_8l_pkg::*;
#(
    parameter int DATA_WIDTH = DESKEW_DATA_WIDTH,
    parameter int LANES      = DESKEW_LANES,
    parameter int FIFO_DEPTH = DESKEW_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DESKEW_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [LANES*DATA_WIDTH-1:0] lane_in,
    input  logic [LANES-1:0]            lane_valid_in,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        clr_flags,
    output logic                        skew_err,
    output logic                        overflow,
    output logic [CNT_WIDTH-1:0]        word_count
);

    logic [LANES*DATA_WIDTH-1:0] aligned_data;
    logic [LANES-1:0]            aligned_vld;
    align_e                      align_state;
    logic                        fifo_full;
    logic                        fifo_drop;

    // Lane k is delayed by LANES-1-k cycles so every lane lands in the same cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int STAGES = LANES - 1 - k;

        if (STAGES == 0) begin : g_pass
            assign aligned_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_in[k*DATA_WIDTH +: DATA_WIDTH];
            assign aligned_vld[k]                           = lane_valid_in[k];
        end else begin : g_pipe
            logic [DATA_WIDTH-1:0] data_q  [STAGES];
            logic                  valid_q [STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < STAGES; s++) begin
                        data_q[s]  <= '0;
                        valid_q[s] <= 1'b0;
                    end
                end else begin
                    data_q[0]  <= lane_in[k*DATA_WIDTH +: DATA_WIDTH];
                    valid_q[0] <= lane_valid_in[k];
                    for (int s = 1; s < STAGES; s++) begin
                        data_q[s]  <= data_q[s-1];
                        valid_q[s] <= valid_q[s-1];
                    end
                end
            end

            assign aligned_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[STAGES-1];
            assign aligned_vld[k]                           = valid_q[STAGES-1];
        end
    end

    assign align_state = align_class(&aligned_vld, |aligned_vld);

    deskew_fifo #(
        .WIDTH (LANES * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (align_state == ALIGN_WORD),
        .wr_data  (aligned_data),
        .rd_en    (out_ready),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .full     (fifo_full),
        .wr_drop  (fifo_drop)
    );

    // A new error in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            skew_err   <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (align_state == ALIGN_SKEW) begin
                skew_err <= 1'b1;
            end else if (clr_flags) begin
                skew_err <= 1'b0;
            end
            if (fifo_drop && fifo_full) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (out_valid && out_ready) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_deskew_8l.sv
// Randomized bench for reg_deskew_8l: staircase lane stimulus checked against a
// queue-based model of the realign / qualify / buffer / count behaviour.
module tb_reg_deskew_8l;

    localparam int DW    = 18;
    localparam int L     = 8;
    localparam int W     = DW * L;
    localparam int DEPTH = 4;

    typedef logic [W-1:0] word_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   lane_in;
    logic [L-1:0]   lane_valid_in;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           clr_flags;
    logic           skew_err;
    logic           overflow;
    logic [15:0]    word_count;

    always #5 clk = ~clk;

    reg_deskew_8l #(
        .DATA_WIDTH (DW),
        .LANES      (L),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .lane_in       (lane_in),
        .lane_valid_in (lane_valid_in),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .clr_flags     (clr_flags),
        .skew_err      (skew_err),
        .overflow      (overflow),
        .word_count    (word_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          t     = 0;
    bit          fix_data = 0;

    // Words indexed by the cycle their lane 0 is presented; lane k replays them k cycles later.
    logic [DW-1:0] ring_data [16][L];
    logic [L-1:0]  ring_mask [16];

    word_t       q[$];
    word_t       exp_data;
    logic [15:0] exp_cnt;
    logic        exp_skew;
    logic        exp_ovf;

    // Drive cycle t, advance the model across the closing edge, land #1 into cycle t+1.
    task automatic step(input logic start, input logic [L-1:0] mask, input logic rdy,
                        input logic clr, input logic rst);
        int          aw;
        logic [L-1:0] am;
        logic        rd;
        logic        set_s;
        logic        set_o;
        word_t       w;
        ring_mask[t & 15] = start ? mask : '0;
        for (int k = 0; k < L; k++)
            ring_data[t & 15][k] = fix_data ? DW'(32'h100 + k) : DW'($urandom);
        for (int k = 0; k < L; k++) begin
            lane_in[k*DW +: DW] = ring_data[(t - k) & 15][k];
            lane_valid_in[k]    = ring_mask[(t - k) & 15][k];
        end
        out_ready = rdy;
        clr_flags = clr;
        reset     = rst;
        if (rst) begin
            q.delete();
            exp_skew = 1'b0;
            exp_ovf  = 1'b0;
            exp_cnt  = '0;
            exp_data = '0;
            for (int i = 0; i < 16; i++) ring_mask[i] = '0;
        end else begin
            aw    = t - (L - 1);
            am    = ring_mask[aw & 15];
            rd    = (q.size() != 0) && rdy;
            set_o = 1'b0;
            if (rd) begin
                void'(q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            set_s = (am != '0) && (am != '1);
            if (am == '1) begin
                for (int k = 0; k < L; k++) w[k*DW +: DW] = ring_data[aw & 15][k];
                if (q.size() < DEPTH) q.push_back(w);
                else set_o = 1'b1;
            end
            exp_skew = set_s ? 1'b1 : (clr ? 1'b0 : exp_skew);
            exp_ovf  = set_o ? 1'b1 : (clr ? 1'b0 : exp_ovf);
            if (q.size() != 0) exp_data = q[0];
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_cmp++; if (skew_err !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got skew=%b ovf=%b want 0 0", skew_err, overflow); end
        n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", word_count); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        word_t ref_w;
        for (int k = 0; k < L; k++) ref_w[k*DW +: DW] = DW'(32'h100 + k);
        fix_data = 1;
        step(1'b1, '1, 1'b1, 1'b0, 1'b0);
        fix_data = 0;
        for (int n = 1; n <= 10; n++) begin
            n_cmp++; if (out_valid !== (n == L)) begin n_bad++; $display("FAIL single_valid c+%0d: got %b want %b", n, out_valid, n == L); end
            if (n == L) begin
                n_cmp++; if (out_data !== ref_w) begin n_bad++; $display("FAIL single_data: got %h want %h", out_data, ref_w); end
            end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++; if (word_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", word_count); end
    endtask

    task automatic test_overflow();
        logic [15:0] base = exp_cnt;
        for (int i = 0; i < 8; i++) step(1'b1, '1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_held_valid: got %b want 1", out_valid); end
        n_cmp++; if (word_count !== base) begin n_bad++; $display("FAIL ovf_stall_count: got %0d want %0d", word_count, base); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL ovf_drain_valid %0d: got %b want %b", i, out_valid, q.size() != 0); end
            n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL ovf_drain_data %0d: got %h want %h", i, out_data, exp_data); end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++; if (word_count !== base + 16'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want %0d", word_count, base + 16'd4); end
    endtask

    task automatic test_stream();
        logic [15:0] base;
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        base = exp_cnt;
        for (int i = 0; i < 31; i++) begin
            step(1'b1, '1, (i >= 11), 1'b0, 1'b0);
            n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL stream_valid %0d: got %b want %b", i, out_valid, q.size() != 0); end
            n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL stream_data %0d: got %h want %h", i, out_data, exp_data); end
            n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL stream_ovf %0d: got %b want 0", i, overflow); end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL stream_tail_data %0d: got %h want %h", i, out_data, exp_data); end
        end
        n_cmp++; if (word_count !== base + 16'd31) begin n_bad++; $display("FAIL stream_count: got %0d want %0d", word_count, base + 16'd31); end
    endtask

    task automatic test_skew();
        logic [15:0] base;
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        base = exp_cnt;
        n_cmp++; if (skew_err !== 1'b0) begin n_bad++; $display("FAIL skew_pre: got %b want 0", skew_err); end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i == 2) ? 8'hF7 : 8'hFF, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL skew_data %0d: got %h want %h", i, out_data, exp_data); end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL skew_valid %0d: got %b want %b", i, out_valid, q.size() != 0); end
            n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL skew_tail_data %0d: got %h want %h", i, out_data, exp_data); end
        end
        n_cmp++; if (skew_err !== 1'b1) begin n_bad++; $display("FAIL skew_flag: got %b want 1", skew_err); end
        n_cmp++; if (word_count !== base + 16'd4) begin n_bad++; $display("FAIL skew_count: got %0d want %0d", word_count, base + 16'd4); end
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (skew_err !== 1'b0) begin n_bad++; $display("FAIL skew_clear: got %b want 0", skew_err); end
    endtask

    task automatic test_random();
        logic [L-1:0] m;
        for (int i = 0; i < 400; i++) begin
            m = ($urandom_range(0, 7) == 0) ? L'($urandom) : '1;
            step(($urandom_range(0, 3) != 0), m, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0), 1'b0);
            n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rand_valid t=%0d: got %b want %b", t, out_valid, q.size() != 0); end
            n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL rand_data t=%0d: got %h want %h", t, out_data, exp_data); end
            n_cmp++; if (skew_err !== exp_skew || overflow !== exp_ovf) begin n_bad++; $display("FAIL rand_flags t=%0d: got skew=%b ovf=%b want %b %b", t, skew_err, overflow, exp_skew, exp_ovf); end
            n_cmp++; if (word_count !== exp_cnt) begin n_bad++; $display("FAIL rand_count t=%0d: got %0d want %0d", t, word_count, exp_cnt); end
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (word_count !== exp_cnt) begin n_bad++; $display("FAIL rand_final_count: got %0d want %0d", word_count, exp_cnt); end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, '1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid %0d: got %b want 0", i, out_valid); end
            n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL midrst_data %0d: got %h want 0", i, out_data); end
            n_cmp++; if (word_count !== 16'd0 || skew_err !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_state %0d: got cnt=%0d skew=%b ovf=%b want 0 0 0", i, word_count, skew_err, overflow); end
        end
    endtask

    task automatic test_wrap();
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 65535; i++) step(1'b1, '1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (word_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_max: got %h want ffff", word_count); end
        step(1'b1, '1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (word_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero: got %h want 0000", word_count); end
        n_cmp++; if (overflow !== 1'b0 || skew_err !== 1'b0) begin n_bad++; $display("FAIL wrap_flags: got skew=%b ovf=%b want 0 0", skew_err, overflow); end
    endtask

    initial begin
        reset         = 1'b1;
        out_ready     = 1'b0;
        clr_flags     = 1'b0;
        lane_in       = '0;
        lane_valid_in = '0;
        exp_data      = '0;
        exp_cnt       = '0;
        exp_skew      = 1'b0;
        exp_ovf       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ring_mask[i] = '0;
            for (int k = 0; k < L; k++) ring_data[i][k] = '0;
        end
        test_reset();
        test_single();
        test_overflow();
        test_stream();
        test_skew();
        test_random();
        test_reset_midstream();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
